// File: rtl/rammodel_arb_pkg.sv
// Shared constants and helpers for the RAM-model read-port arbiter:
// select-width calculation and downstream ID prefix/extract functions.
package rammodel_arb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Width of the master-index prefix; at least one bit even for a single master.
  function automatic int calc_sel_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] id_prefix(input logic [31:0] sel,
                                            input logic [31:0] id,
                                            input int id_w);
    return (sel << id_w) | id;
  endfunction

  function automatic logic [31:0] id_extract_sel(input logic [31:0] rid,
                                                 input int id_w);
    return rid >> id_w;
  endfunction

endpackage

// File: rtl/rammodel_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant in
// cyclic order, reported as one-hot, index and any flag.
module rammodel_rr_pick #(
  parameter int N     = 2,
  parameter int SEL_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any_grant
);

  always_comb begin
    logic [SEL_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    // Scan from farthest to nearest so the nearest requester is written last.
    for (int k = N; k >= 1; k--) begin
      cand = SEL_W'((int'(last_grant) + k) % N);
      if (req[cand]) begin
        grant_idx = cand;
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/rammodel_rd_arbiter.sv
// Round-robin AR arbiter with one-entry AR stage, per-master outstanding limit
// and ID-prefix R routing. Optional grant counters: RAMMODEL_RDARB_STATS_EN.
module rammodel_rd_arbiter
  import rammodel_arb_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SEL_W          = calc_sel_w(NUM_MASTERS)
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [NUM_MASTERS-1:0]            s_arvalid,
  output logic [NUM_MASTERS-1:0]            s_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   s_arid,
  input  logic [NUM_MASTERS*8-1:0]          s_arlen,
  output logic [NUM_MASTERS-1:0]            s_rvalid,
  input  logic [NUM_MASTERS-1:0]            s_rready,
  output logic [DATA_WIDTH-1:0]             s_rdata,
  output logic [1:0]                        s_rresp,
  output logic [ID_WIDTH-1:0]               s_rid,
  output logic                              s_rlast,
  output logic                              m_arvalid,
  input  logic                              m_arready,
  output logic [ADDR_WIDTH-1:0]             m_araddr,
  output logic [ID_WIDTH+SEL_W-1:0]         m_arid,
  output logic [7:0]                        m_arlen,
  input  logic                              m_rvalid,
  output logic                              m_rready,
  input  logic [DATA_WIDTH-1:0]             m_rdata,
  input  logic [1:0]                        m_rresp,
  input  logic [ID_WIDTH+SEL_W-1:0]         m_rid,
  input  logic                              m_rlast
`ifdef RAMMODEL_RDARB_STATS_EN
  ,
  output logic [NUM_MASTERS*32-1:0]         stat_grants
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int DID_W = ID_WIDTH + SEL_W;

  logic                    ar_valid_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DID_W-1:0]        id_reg;
  logic [7:0]              len_reg;
  logic [SEL_W-1:0]        last_grant_reg;
  logic [CNT_W-1:0]        outstanding_reg [NUM_MASTERS];

  logic [NUM_MASTERS-1:0]  eligible;
  logic [NUM_MASTERS-1:0]  gnt;
  logic [NUM_MASTERS-1:0]  r_done;
  logic [SEL_W-1:0]        gnt_idx;
  logic                    any_gnt;
  logic                    can_load;
  logic                    ar_hs;

  logic [ADDR_WIDTH-1:0]   pick_addr;
  logic [ID_WIDTH-1:0]     pick_id;
  logic [7:0]              pick_len;
  logic [31:0]             pick_did32;
  logic [DID_W-1:0]        pick_did;
  logic [31:0]             rsel32;
  logic [SEL_W-1:0]        rsel;
  logic                    unused_bits;

  // ---------------- AR arbitration ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_elig
      assign eligible[gi] = s_arvalid[gi] &&
                            (outstanding_reg[gi] < CNT_W'(MAX_OUTSTANDING));
    end
  endgenerate

  rammodel_rr_pick #(
    .N     (NUM_MASTERS),
    .SEL_W (SEL_W)
  ) u_pick (
    .req        (eligible),
    .last_grant (last_grant_reg),
    .grant      (gnt),
    .grant_idx  (gnt_idx),
    .any_grant  (any_gnt)
  );

  // The stage can take a new request if empty or draining this cycle.
  assign can_load  = !ar_valid_reg || m_arready;
  assign s_arready = (areset || !can_load) ? '0 : gnt;
  assign ar_hs     = any_gnt && can_load && !areset;

  always_comb begin
    pick_addr = s_araddr[ADDR_WIDTH-1:0];
    pick_id   = s_arid[ID_WIDTH-1:0];
    pick_len  = s_arlen[7:0];
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        pick_addr = s_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_id   = s_arid[i*ID_WIDTH +: ID_WIDTH];
        pick_len  = s_arlen[i*8 +: 8];
      end
    end
  end

  assign pick_did32 = id_prefix(32'(gnt_idx), 32'(pick_id), ID_WIDTH);
  assign pick_did   = pick_did32[DID_W-1:0];

  always_ff @(posedge aclk) begin
    if (areset) begin
      ar_valid_reg   <= 1'b0;
      addr_reg       <= '0;
      id_reg         <= '0;
      len_reg        <= '0;
      last_grant_reg <= SEL_W'(NUM_MASTERS - 1);
    end else begin
      if (ar_hs) begin
        ar_valid_reg   <= 1'b1;
        addr_reg       <= pick_addr;
        id_reg         <= pick_did;
        len_reg        <= pick_len;
        last_grant_reg <= gnt_idx;
      end else if (m_arready) begin
        ar_valid_reg   <= 1'b0;
      end
    end
  end

  assign m_arvalid = ar_valid_reg;
  assign m_araddr  = addr_reg;
  assign m_arid    = id_reg;
  assign m_arlen   = len_reg;

  // ---------------- R routing ----------------
  assign rsel32 = id_extract_sel(32'(m_rid), ID_WIDTH);
  assign rsel   = rsel32[SEL_W-1:0];
  assign unused_bits = ^{rsel32[31:SEL_W], pick_did32[31:DID_W]};

  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rid   = m_rid[ID_WIDTH-1:0];
  assign s_rlast = m_rlast;

  // An index with no matching master leaves m_rready high, so the beat drains.
  always_comb begin
    m_rready = 1'b1;
    s_rvalid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (rsel == SEL_W'(i)) begin
        m_rready    = s_rready[i];
        s_rvalid[i] = m_rvalid;
      end
    end
  end

  // ---------------- Outstanding-burst counters ----------------
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cnt
      logic inc;
      assign r_done[gi] = m_rvalid && m_rready && m_rlast && (rsel == SEL_W'(gi));
      assign inc        = s_arready[gi];

      always_ff @(posedge aclk) begin
        if (areset) begin
          outstanding_reg[gi] <= '0;
        end else if (inc && !r_done[gi]) begin
          outstanding_reg[gi] <= outstanding_reg[gi] + CNT_W'(1);
        end else if (r_done[gi] && !inc && (outstanding_reg[gi] != '0)) begin
          outstanding_reg[gi] <= outstanding_reg[gi] - CNT_W'(1);
        end
      end
    end
  endgenerate

`ifdef RAMMODEL_RDARB_STATS_EN
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_stats
      logic [31:0] grants_reg;
      always_ff @(posedge aclk) begin
        if (areset) begin
          grants_reg <= '0;
        end else if (s_arready[gi]) begin
          grants_reg <= grants_reg + 32'd1;
        end
      end
      assign stat_grants[gi*32 +: 32] = grants_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_rammodel_rd_arbiter.sv
// Self-checking bench for rammodel_rd_arbiter: directed scenarios then random
// traffic, all checked against a transaction-level model of the arbiter.
module tb_rammodel_rd_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int IW  = 4;
  localparam int MO  = 4;
  localparam int SW  = 1;
  localparam int DIW = IW + SW;

  logic            aclk = 1'b0;
  logic            areset = 1'b1;
  logic [N-1:0]    s_arvalid = '0;
  logic [N-1:0]    s_arready;
  logic [N*AW-1:0] s_araddr = '0;
  logic [N*IW-1:0] s_arid = '0;
  logic [N*8-1:0]  s_arlen = '0;
  logic [N-1:0]    s_rvalid;
  logic [N-1:0]    s_rready = '0;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic [IW-1:0]   s_rid;
  logic            s_rlast;
  logic            m_arvalid;
  logic            m_arready = 1'b0;
  logic [AW-1:0]   m_araddr;
  logic [DIW-1:0]  m_arid;
  logic [7:0]      m_arlen;
  logic            m_rvalid = 1'b0;
  logic            m_rready;
  logic [DW-1:0]   m_rdata = '0;
  logic [1:0]      m_rresp = '0;
  logic [DIW-1:0]  m_rid = '0;
  logic            m_rlast = 1'b0;
`ifdef RAMMODEL_RDARB_STATS_EN
  logic [N*32-1:0] stat_grants;
`endif

  always #5 aclk = ~aclk;

  rammodel_rd_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rid(s_rid), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rid(m_rid), .m_rlast(m_rlast)
`ifdef RAMMODEL_RDARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  typedef struct {
    logic [DIW-1:0] id;
    logic [7:0]     len;
  } burst_t;

  // Reference model state: per-master burst counts, AR stage contents,
  // downstream bursts awaiting R data, grant totals.
  int             mo_cnt [N];
  int             gcnt   [N];
  int             m_last;
  bit             buf_v;
  logic [AW-1:0]  buf_addr;
  logic [DIW-1:0] buf_id;
  logic [7:0]     buf_len;
  burst_t         sq [$];
  int             beat;
  bit             last_rhs;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mo_cnt[i] = 0;
      gcnt[i]   = 0;
    end
    m_last = N - 1;
    buf_v  = 1'b0;
    sq.delete();
    beat = 0;
  endtask

  // One clock: inputs are already driven; predict, compare, clock, update model.
  task automatic step();
    logic [N-1:0] exp_ar;
    logic [N-1:0] exp_rv;
    logic         exp_mr;
    int           g;
    int           sel;
    bit           mhs;
    exp_ar = '0;
    g = -1;
    if (!areset && (!buf_v || m_arready)) begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && s_arvalid[c] && mo_cnt[c] < MO) begin
          g = c;
          exp_ar[c] = 1'b1;
        end
      end
    end
    sel = int'(m_rid[DIW-1:IW]);
    exp_rv = '0;
    exp_mr = 1'b1;
    if (sel < N) begin
      exp_rv[sel] = m_rvalid;
      exp_mr = s_rready[sel];
    end
    #1;
    $display("t=%0t arvalid=%b arready=%b m_arvalid=%b m_arid=%h rvalid=%b rid=%h", $time,
             s_arvalid, s_arready, m_arvalid, m_arid, m_rvalid, m_rid);
    chk("s_arready", 64'(s_arready), 64'(exp_ar));
    chk("m_arvalid", 64'(m_arvalid), 64'(buf_v));
    if (buf_v) begin
      chk("m_araddr", 64'(m_araddr), 64'(buf_addr));
      chk("m_arid", 64'(m_arid), 64'(buf_id));
      chk("m_arlen", 64'(m_arlen), 64'(buf_len));
    end
    chk("s_rvalid", 64'(s_rvalid), 64'(exp_rv));
    chk("m_rready", 64'(m_rready), 64'(exp_mr));
    if (m_rvalid) begin
      chk("s_rid", 64'(s_rid), 64'(m_rid[IW-1:0]));
      chk("s_rdata", s_rdata, m_rdata);
      chk("s_rlast", 64'(s_rlast), 64'(m_rlast));
      chk("s_rresp", 64'(s_rresp), 64'(m_rresp));
    end
    mhs = buf_v && m_arready;
    last_rhs = m_rvalid && exp_mr;
    @(posedge aclk);
    if (areset) begin
      model_reset();
    end else begin
      if (mhs) begin
        sq.push_back('{id: buf_id, len: buf_len});
        buf_v = 1'b0;
      end
      if (g >= 0) begin
        buf_v    = 1'b1;
        buf_addr = s_araddr[g*AW +: AW];
        buf_id   = {SW'(g), s_arid[g*IW +: IW]};
        buf_len  = s_arlen[g*8 +: 8];
        m_last   = g;
        mo_cnt[g]++;
        gcnt[g]++;
      end
      if (last_rhs && m_rlast && sel < N) mo_cnt[sel]--;
    end
    #1;
  endtask

  task automatic do_reset();
    m_rvalid  = 1'b0;
    m_rlast   = 1'b0;
    s_arvalid = '0;
    areset    = 1'b1;
    step();
    areset    = 1'b0;
  endtask

  task automatic rand_ar();
    s_araddr = {$urandom, $urandom};
    s_arid   = N*IW'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge aclk);
    #1;

    // Reset: requests present but no s_arready while areset is high.
    s_arvalid = 2'b11;
    step();
    areset = 1'b0;

    // Both masters requesting, downstream always ready: strict alternation.
    m_arready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_ar();
      s_arlen = {8'd0, 8'd0};
      step();
      chk("alt_grant", 64'(m_arid[DIW-1]), 64'(k % 2));
    end

    // Buffer full and downstream stalled: no grants, stage stable.
    do_reset();
    s_arvalid = 2'b11;
    rand_ar();
    step();
    m_arready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_ar();
      step();
    end
    m_arready = 1'b1;
    rand_ar();
    step();

    // Outstanding limit on m0, m1 still served, completion restores m0.
    do_reset();
    s_arvalid = 2'b01;
    s_arlen   = {8'd3, 8'd3};
    for (int k = 0; k < 4; k++) begin
      rand_ar();
      step();
    end
    s_arvalid = 2'b11;
    step();
    s_arvalid = 2'b01;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rid     = 5'h02;
    s_rready  = 2'b01;
    step();
    m_rvalid  = 1'b0;
    step();

    // Routed beat held by a not-ready master, then completed.
    s_arvalid = 2'b00;
    m_rvalid  = 1'b1;
    m_rlast   = 1'b1;
    m_rid     = 5'h15;
    m_rdata   = 64'h0123_4567_89ab_cdef;
    s_rready  = 2'b00;
    step();
    s_rready  = 2'b10;
    step();
    m_rvalid  = 1'b0;

    // Same-cycle AR and completion for m0 keeps its count unchanged.
    do_reset();
    s_arvalid = 2'b01;
    for (int k = 0; k < 3; k++) step();
    m_rvalid = 1'b1;
    m_rlast  = 1'b1;
    m_rid    = 5'h03;
    s_rready = 2'b01;
    step();
    m_rvalid = 1'b0;
    step();
    step();

    // Random traffic with a simple in-order downstream slave.
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit drove;
      s_arvalid = N'($urandom);
      rand_ar();
      for (int i = 0; i < N; i++) s_arlen[i*8 +: 8] = 8'($urandom_range(0, 3));
      m_arready = ($urandom % 4) != 0;
      s_rready  = N'($urandom);
      drove = (sq.size() > 0) && (($urandom % 3) != 0);
      if (drove) begin
        m_rvalid = 1'b1;
        m_rid    = sq[0].id;
        m_rlast  = (beat == int'(sq[0].len));
        m_rdata  = {$urandom, $urandom};
        m_rresp  = 2'($urandom);
      end else begin
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
        m_rid    = DIW'($urandom);
      end
      step();
      if (drove && last_rhs) begin
        if (m_rlast) begin
          void'(sq.pop_front());
          beat = 0;
        end else begin
          beat++;
        end
      end
    end

`ifdef RAMMODEL_RDARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("stat_grants", 64'(stat_grants[i*32 +: 32]), 64'(gcnt[i]));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
